// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a 16-bit word-count header from a byte stream,
// packs big-endian 32-bit words, writes them to imem, then releases the CPU.
module imem_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              cpu_run,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_e;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_e              state_q;
    logic                rx_ready_q;
    logic                wr_en_q;
    logic [31:0]         wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                busy_q;
    logic                cpu_run_q;
    logic                err_q;
    logic [ADDR_W:0]     word_count_q;
    logic [1:0]          byte_cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [15:0]         n_q;
    logic [31:0]         word_q;

    logic                xfer;
    logic [15:0]         hdr_n_d;
    logic [31:0]         word_d;
    logic [ADDR_W:0]     idx_inc_d;

    assign xfer      = rx_valid && rx_ready_q;
    // The header decision must see the low byte arriving on this very edge.
    assign hdr_n_d   = {n_q[15:8], rx_data};
    assign word_d    = {word_q[23:0], rx_data};
    assign idx_inc_d = {1'b0, idx_q} + 1'b1;

    // NOTE: every output is a register updated on the transition into the state
    // that owns it, so outputs line up with the state they describe; all state
    // here uses non-blocking assignment so updates within one edge never race.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            cpu_run_q    <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            byte_cnt_q   <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            word_q       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q      <= HDR_HI;
                        rx_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        cpu_run_q    <= 1'b0;
                        err_q        <= 1'b0;
                        word_count_q <= '0;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        n_q[15:8] <= rx_data;
                        state_q   <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        n_q[7:0] <= rx_data;
                        if (hdr_n_d == 16'd0) begin
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            cpu_run_q  <= 1'b1;
                        end else if (32'(hdr_n_d) > CAPACITY) begin
                            state_q    <= ERR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q    <= DATA;
                            byte_cnt_q <= '0;
                            idx_q      <= '0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            rx_ready_q   <= 1'b0;
                            wr_en_q      <= 1'b1;
                            wr_data_q    <= word_d;
                            wr_addr_q    <= BASE_ADDR + 32'({idx_q, 2'b00});
                            word_count_q <= idx_inc_d;
                        end
                    end
                end
                WRITE: begin
                    if (32'(idx_inc_d) == 32'(n_q)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        cpu_run_q <= 1'b1;
                    end else begin
                        state_q    <= DATA;
                        rx_ready_q <= 1'b1;
                        byte_cnt_q <= '0;
                        idx_q      <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_run_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign cpu_run    = cpu_run_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level model predicts writes, final
// flags and word_count for each load; a negedge monitor captures writes.
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int CAP    = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef wr_t wr_q_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              cpu_run;
    logic              err;
    logic [ADDR_W:0]   word_count;

    wr_q_t got;
    int    viol;
    int    n_tests = 0;
    int    n_fail  = 0;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .cpu_run(cpu_run), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Writes are captured here; handshake-shape violations are tallied per load.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) got.push_back('{wr_addr, wr_data});
            if (rx_ready && !busy) viol++;
            if (busy && !rx_ready && !wr_en) viol++;
            if (wr_en && !busy) viol++;
        end
    end

    // Reference: header gives N; valid N yields N sequential big-endian words.
    function automatic void model(input byte_q_t s, output wr_q_t exp,
                                  output bit e_err, output bit e_run, output int e_wc);
        int n;
        exp = {};
        n = int'(s[0]) * 256 + int'(s[1]);
        e_err = (n > CAP);
        e_run = !e_err;
        e_wc  = e_err ? 0 : n;
        if (!e_err) begin
            for (int i = 0; i < n; i++) begin
                exp.push_back('{BASE + 32'(4 * i),
                                {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]}});
            end
        end
    endfunction

    function automatic byte_q_t make_stream(input int n);
        byte_q_t s;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        if (n >= 1 && n <= CAP) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
        end
        return s;
    endfunction

    function automatic byte_q_t nominal_stream();
        logic [7:0] arr [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                                 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        byte_q_t s;
        foreach (arr[i]) s.push_back(arr[i]);
        return s;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, t);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, t);
        end
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each byte.
    task automatic run_load(input byte_q_t s, input int gap, input bit poke, input string name);
        wr_q_t exp;
        bit    e_err, e_run;
        int    e_wc;
        got.delete();
        viol = 0;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_run !== 1'b0 || err !== 1'b0 || word_count !== '0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b rx_ready=%b cpu_run=%b err=%b word_count=%0d, required 1 1 0 0 0",
                     name, busy, rx_ready, cpu_run, err, word_count);
        end
        for (int i = 0; i < s.size(); i++) begin
            if (poke && i == 6) pulse_start();
            send_byte(s[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
        wait_idle(name);
        model(s, exp, e_err, e_run, e_wc);
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s_nwrites: got %0d, required %0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL %s_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                         name, i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
            end
        end
        n_tests++;
        if (cpu_run !== e_run || err !== e_err || word_count !== 7'(e_wc) || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: cpu_run=%b err=%b word_count=%0d rx_ready=%b, required %b %b %0d 0",
                     name, cpu_run, err, word_count, rx_ready, e_run, e_err, e_wc);
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL %s_handshake: %0d ready/busy/wr_en violations, required 0", name, viol);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        n_tests++;
        if (rx_ready !== 1'b0 || got.size() != exp.size() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stale: rx_ready=%b busy=%b nwrites=%0d, required 0 0 %0d",
                     name, rx_ready, busy, got.size(), exp.size());
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            start    = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        n_tests++;
        if ({rx_ready, wr_en, busy, cpu_run, err} !== 5'b0 || word_count !== '0 ||
            wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: rdy/wr/busy/run/err=%b wc=%0d addr=%h data=%h, required all 0",
                     {rx_ready, wr_en, busy, cpu_run, err}, word_count, wr_addr, wr_data);
        end
        start = 1'b0; rx_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        run_load(nominal_stream(), 0, 1'b0, "nominal");
        n_tests++;
        if (got.size() < 2 || got[0] !== '{32'h0, 32'h20080005} || got[1] !== '{32'h4, 32'h2009000A} ||
            cpu_run !== 1'b1 || word_count !== 7'd2) begin
            n_fail++;
            $display("FAIL nominal_fixed: n=%0d cpu_run=%b wc=%0d, required 2 writes 0:20080005 4:2009000a run=1 wc=2",
                     got.size(), cpu_run, word_count);
        end
    endtask

    task automatic test_backpressure();
        run_load(nominal_stream(), 3, 1'b0, "backpressure");
        n_tests++;
        if (got.size() != 2 || got[0].data !== 32'h20080005 || got[1].data !== 32'h2009000A) begin
            n_fail++;
            $display("FAIL backpressure_fixed: n=%0d, required 2 writes 20080005 2009000a", got.size());
        end
    endtask

    task automatic test_boundary();
        run_load(make_stream(0), -1, 1'b0, "count0");
        run_load(make_stream(CAP), -1, 1'b0, "count64");
        n_tests++;
        if (got.size() != CAP || got[CAP-1].addr !== 32'hFC) begin
            n_fail++;
            $display("FAIL count64_last: n=%0d last addr=%h, required 64 at 000000fc",
                     got.size(), (got.size() > 0) ? got[got.size()-1].addr : 32'hX);
        end
        run_load(make_stream(CAP + 1), -1, 1'b0, "count65");
        run_load(make_stream(int'($urandom_range(CAP + 2, 65535))), -1, 1'b0, "count_big");
    endtask

    task automatic test_reset_midload();
        byte_q_t s;
        s = make_stream(2);
        got.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(s[i], 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rx_ready, wr_en, busy, cpu_run, err} !== 5'b0 || word_count !== '0 ||
            wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midload_reset: rdy/wr/busy/run/err=%b wc=%0d addr=%h data=%h, required all 0",
                     {rx_ready, wr_en, busy, cpu_run, err}, word_count, wr_addr, wr_data);
        end
        n_tests++;
        if (got.size() != 1 || got[0].data !== {s[2], s[3], s[4], s[5]}) begin
            n_fail++;
            $display("FAIL midload_prior_write: n=%0d, required 1 write of %h", got.size(), {s[2], s[3], s[4], s[5]});
        end
        rst_n = 1'b1;
        s = {};
        s.push_back(8'h00); s.push_back(8'h01); s.push_back(8'h11);
        s.push_back(8'h22); s.push_back(8'h33); s.push_back(8'h44);
        run_load(s, 0, 1'b0, "after_reset");
        n_tests++;
        if (got.size() != 1 || got[0] !== '{32'h0, 32'h11223344}) begin
            n_fail++;
            $display("FAIL after_reset_fixed: n=%0d, required 1 write 0:11223344", got.size());
        end
    endtask

    task automatic test_start_handling();
        run_load(make_stream(3), -1, 1'b1, "start_in_data");
        run_load(make_stream(2), 0, 1'b0, "start_in_done");
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        n_tests++;
        if (busy !== 1'b0 || cpu_run !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: busy=%b cpu_run=%b rx_ready=%b, required 0 0 0",
                     busy, cpu_run, rx_ready);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_load(make_stream(int'($urandom_range(1, 8))), -1, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_boundary();
        test_reset_midload();
        test_start_handling();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory read path: the pipeline's fetch stage only reads instruction memory, and this block fills that memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and parses a 16-bit word-count header.
- Assembles big-endian 32-bit instruction words and issues one write per word to the instruction memory's write port, at byte addresses matching PC addressing.
- Holds the CPU (cpu_run low) until the load completes successfully.

Parameters:
- ADDR_W, 6, word-index width; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be word aligned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  32  byte address, word aligned.
- wr_data  out  32  instruction word.
- busy  out  1  load in progress.
- cpu_run  out  1  pipeline release; high only after a successful load.
- err  out  1  header count exceeded capacity.
- word_count  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset, meaning rst_n low at a clk edge:
  - state goes to IDLE.
  - rx_ready, wr_en, busy, cpu_run and err go to 0.
  - wr_addr, wr_data and word_count go to 0.
  - The internal byte counter, word index and N go to 0.
  - Reset mid-load has the same effect. Memory words already written are not undone.
- Byte transfer happens on any edge where rx_valid and rx_ready are both high. No transfer otherwise; rx_valid may drop at any time.
- All outputs are registered. rx_ready is high exactly in HDR_HI, HDR_LO and DATA.
- busy is high in HDR_HI, HDR_LO, DATA and WRITE.
- IDLE:
  - start goes to HDR_HI and clears err and word_count.
- HDR_HI:
  - A transfer latches N[15:8] and goes to HDR_LO.
- HDR_LO:
  - A transfer latches N[7:0]. The decision uses the full 16-bit N including this byte.
  - N=0 goes to DONE with word_count=0.
  - N>2^ADDR_W goes to ERR and sets err=1.
  - Otherwise goes to DATA with byte counter=0 and word index=0.
- DATA:
  - Each transfer shifts rx_data into the word, MSB first: word = {word[23:0], rx_data}. The byte counter increments.
  - The 4th transfer goes to WRITE.
- WRITE:
  - Lasts exactly one cycle, with wr_en=1, wr_data=assembled word and wr_addr=BASE_ADDR + 4*index.
  - Latency: wr_en is high on the cycle after the 4th byte transfer.
  - word_count=index+1 is visible from the same cycle.
  - If index+1==N, go to DONE; else index increments and the state returns to DATA.
- DONE:
  - cpu_run=1.
  - start drops cpu_run to 0 on the next cycle and goes to HDR_HI, clearing word_count.
- ERR:
  - No writes. cpu_run stays 0 and err stays 1.
  - start behaves as in IDLE and clears err.
- start is ignored while busy. It is also ignored in IDLE, DONE and ERR if it coincides with rst_n low; reset wins.
- wr_en is never high outside WRITE.
- wr_addr arithmetic is 32-bit. Index wrap cannot occur because N ≤ 2^ADDR_W.
- rx_valid with rx_data present in IDLE, DONE or ERR is not consumed.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs.
  - Required: rx_ready, wr_en, busy, cpu_run and err are all 0; word_count=0.
- Nominal load, BASE_ADDR=0.
  - Stimulus: start, then bytes 00 02 20 08 00 05 20 09 00 0A, rx_valid held high.
  - Required: first write wr_en=1, addr=0x0, data=0x20080005.
  - Required: second write wr_en=1, addr=0x4, data=0x2009000A.
  - Required: then cpu_run=1, word_count=2.
- Backpressure: same stream with rx_valid low for 3 cycles between every byte.
  - Required: identical writes and data; no extra wr_en; rx_ready low only during WRITE.
- Boundary counts.
  - Header 00 00: DONE with cpu_run=1, no wr_en.
  - Header 00 40 with ADDR_W=6: 64 writes, last one at addr 0xFC.
  - Header 00 41 with ADDR_W=6: err=1, cpu_run=0, no wr_en.
- Reset mid-load: rst_n=0 after 2 bytes of the second word.
  - Required: IDLE and all outputs 0.
  - Required: a subsequent full load with header 00 01 11 22 33 44 writes 0x11223344 at addr 0x0.
- Start handling.
  - start pulses during DATA: ignored, load completes normally.
  - start in DONE: cpu_run=0 next cycle, state HDR_HI, word_count=0.
